// File: rtl/iq_dac_driver_if.sv
// Sample/DAC bundle between the I/Q modulator and the DAC driver.
// The master drives samples and strobes; the slave returns DAC codes and RF-chain status.
interface iq_dac_driver_if #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned DAC_W = 6
);
    logic                    sample_strobe;
    logic                    iq_valid;
    logic signed [IN_W-1:0]  inphase_in;
    logic signed [IN_W-1:0]  quadrature_in;
    logic        [DAC_W-1:0] dac_zero;
    logic        [DAC_W-1:0] dac_one;
    logic                    txchain_en;
    logic                    ramp_busy;

    modport master (
        output sample_strobe, iq_valid, inphase_in, quadrature_in,
        input  dac_zero, dac_one, txchain_en, ramp_busy
    );

    modport slave (
        input  sample_strobe, iq_valid, inphase_in, quadrature_in,
        output dac_zero, dac_one, txchain_en, ramp_busy
    );
endinterface

// File: rtl/iq_dac_driver.sv
// I/Q DAC driver: burst gain ramping, requantisation to offset-binary DAC codes,
// and RF chain enable. All state advances only on sample strobes.
module iq_dac_driver #(
    parameter int unsigned IN_W      = 9,
    parameter int unsigned DAC_W     = 6,
    parameter int unsigned RAMP_LOG2 = 2,
    parameter int unsigned ROUND     = 1,
    parameter int unsigned SWAP_IQ   = 0
) (
    input logic           clock,
    input logic           reset_n,
    iq_dac_driver_if.slave bus
);
    localparam int unsigned RAMP_LEN = 1 << RAMP_LOG2;
    localparam int unsigned GW       = RAMP_LOG2 + 1;
    localparam int unsigned PW       = IN_W + RAMP_LOG2 + 1;
    localparam int unsigned SH       = IN_W - DAC_W;

    localparam logic [GW-1:0]        GMax    = GW'(RAMP_LEN);
    localparam logic [GW-1:0]        GOne    = GW'(1);
    localparam logic [DAC_W-1:0]     MidCode = DAC_W'(1 << (DAC_W - 1));
    localparam logic signed [PW:0]   RndAdd  = (ROUND != 0) ? (PW+1)'(1 << (SH - 1))
                                                            : (PW+1)'(0);
    localparam logic signed [PW:0]   RMax    = (PW+1)'((1 << (DAC_W - 1)) - 1);
    localparam logic signed [PW:0]   RMin    = (PW+1)'(-(1 << (DAC_W - 1)));

    typedef enum logic [1:0] {StIdle, StRampUp, StActive, StRampDown} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           g_q, g_d;
    logic signed [IN_W-1:0]  samp_i_q, samp_i_d, samp_q_q, samp_q_d;
    logic [DAC_W-1:0]        dac_zero_q, dac_zero_d, dac_one_q, dac_one_d;
    logic                    tx_q, tx_d, busy_q, busy_d;

    // Scale by g/RAMP_LEN, round/truncate to DAC_W, saturate, convert to offset binary.
    function automatic logic [DAC_W-1:0] requant(input logic signed [IN_W-1:0] x,
                                                 input logic [GW-1:0] g);
        logic signed [PW-1:0] prod;
        logic signed [PW:0]   acc;
        prod = PW'(x) * $signed(PW'(g));
        acc  = (PW+1)'(prod >>> RAMP_LOG2) + RndAdd;
        acc  = acc >>> SH;
        if (acc > RMax) begin
            acc = RMax;
        end else if (acc < RMin) begin
            acc = RMin;
        end
        return {~acc[DAC_W-1], acc[DAC_W-2:0]};
    endfunction

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        samp_i_d   = samp_i_q;
        samp_q_d   = samp_q_q;
        dac_zero_d = dac_zero_q;
        dac_one_d  = dac_one_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        if (bus.sample_strobe) begin
            if (bus.iq_valid) begin
                samp_i_d = bus.inphase_in;
                samp_q_d = bus.quadrature_in;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.iq_valid) begin
                        g_d     = GOne;
                        state_d = (g_d == GMax) ? StActive : StRampUp;
                    end else begin
                        g_d = '0;
                    end
                end
                StRampUp, StRampDown: begin
                    if (bus.iq_valid) begin
                        g_d     = g_q + GOne;
                        state_d = (g_d == GMax) ? StActive : StRampUp;
                    end else begin
                        g_d     = g_q - GOne;
                        state_d = (g_d == '0) ? StIdle : StRampDown;
                    end
                end
                StActive: begin
                    if (bus.iq_valid) begin
                        g_d = GMax;
                    end else begin
                        g_d     = GMax - GOne;
                        state_d = (g_d == '0) ? StIdle : StRampDown;
                    end
                end
                default: begin
                    state_d = StIdle;
                    g_d     = '0;
                end
            endcase

            if (state_d == StIdle) begin
                dac_zero_d = MidCode;
                dac_one_d  = MidCode;
            end else if (SWAP_IQ != 0) begin
                dac_zero_d = requant(samp_q_d, g_d);
                dac_one_d  = requant(samp_i_d, g_d);
            end else begin
                dac_zero_d = requant(samp_i_d, g_d);
                dac_one_d  = requant(samp_q_d, g_d);
            end
            tx_d   = (state_d != StIdle);
            busy_d = (state_d == StRampUp) || (state_d == StRampDown);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            g_q        <= '0;
            samp_i_q   <= '0;
            samp_q_q   <= '0;
            dac_zero_q <= MidCode;
            dac_one_q  <= MidCode;
            tx_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            samp_i_q   <= samp_i_d;
            samp_q_q   <= samp_q_d;
            dac_zero_q <= dac_zero_d;
            dac_one_q  <= dac_one_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.dac_zero   = dac_zero_q;
    assign bus.dac_one    = dac_one_q;
    assign bus.txchain_en = tx_q;
    assign bus.ramp_busy  = busy_q;
endmodule

// File: tb/tb_iq_dac_driver.sv
// Bench for iq_dac_driver: default, SWAP_IQ=1 and ROUND=0 instances share one stimulus
// stream and are compared every cycle against a gain/sample reference model.
module tb_iq_dac_driver;
    localparam int IN_W = 9;
    localparam int DAC_W = 6;
    localparam int RL = 2;
    localparam int LEN = 1 << RL;
    localparam int MID = 1 << (DAC_W - 1);

    logic clock;
    logic reset_n;
    logic strobe;
    logic valid;
    logic signed [IN_W-1:0] in_i;
    logic signed [IN_W-1:0] in_q;
    bit cmp_en;

    int vectors;
    int errors;

    // Reference model: gain counts up on valid strobes, down on invalid ones, clamped.
    int m_g;
    int m_i;
    int m_q;

    iq_dac_driver_if #(.IN_W(IN_W), .DAC_W(DAC_W)) bus0 ();
    iq_dac_driver_if #(.IN_W(IN_W), .DAC_W(DAC_W)) bus_s ();
    iq_dac_driver_if #(.IN_W(IN_W), .DAC_W(DAC_W)) bus_t ();

    assign bus0.sample_strobe  = strobe;
    assign bus0.iq_valid       = valid;
    assign bus0.inphase_in     = in_i;
    assign bus0.quadrature_in  = in_q;
    assign bus_s.sample_strobe = strobe;
    assign bus_s.iq_valid      = valid;
    assign bus_s.inphase_in    = in_i;
    assign bus_s.quadrature_in = in_q;
    assign bus_t.sample_strobe = strobe;
    assign bus_t.iq_valid      = valid;
    assign bus_t.inphase_in    = in_i;
    assign bus_t.quadrature_in = in_q;

    iq_dac_driver #(.IN_W(IN_W), .DAC_W(DAC_W), .RAMP_LOG2(RL), .ROUND(1), .SWAP_IQ(0)) dut0 (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus0.slave)
    );
    iq_dac_driver #(.IN_W(IN_W), .DAC_W(DAC_W), .RAMP_LOG2(RL), .ROUND(1), .SWAP_IQ(1)) dut_s (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_s.slave)
    );
    iq_dac_driver #(.IN_W(IN_W), .DAC_W(DAC_W), .RAMP_LOG2(RL), .ROUND(0), .SWAP_IQ(0)) dut_t (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_t.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_g <= 0;
            m_i <= 0;
            m_q <= 0;
        end else if (strobe) begin
            if (valid) begin
                m_g <= (m_g < LEN) ? m_g + 1 : LEN;
                m_i <= int'(in_i);
                m_q <= int'(in_q);
            end else begin
                m_g <= (m_g > 0) ? m_g - 1 : 0;
            end
        end
    end

    function automatic int exp_code(int x, int g, bit rnd);
        int s;
        int r;
        if (g == 0) return MID;
        s = (x * g) >>> RL;
        r = (s + (rnd ? (1 << (IN_W - DAC_W - 1)) : 0)) >>> (IN_W - DAC_W);
        if (r > MID - 1) r = MID - 1;
        if (r < -MID) r = -MID;
        return r + MID;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("m_zero", int'(bus0.dac_zero), exp_code(m_i, m_g, 1'b1));
            check("m_one", int'(bus0.dac_one), exp_code(m_q, m_g, 1'b1));
            check("m_tx", int'(bus0.txchain_en), int'(m_g != 0));
            check("m_busy", int'(bus0.ramp_busy), int'(m_g != 0 && m_g != LEN));
            check("m_swap_zero", int'(bus_s.dac_zero), exp_code(m_q, m_g, 1'b1));
            check("m_swap_one", int'(bus_s.dac_one), exp_code(m_i, m_g, 1'b1));
            check("m_swap_tx", int'(bus_s.txchain_en), int'(m_g != 0));
            check("m_trunc_zero", int'(bus_t.dac_zero), exp_code(m_i, m_g, 1'b0));
            check("m_trunc_one", int'(bus_t.dac_one), exp_code(m_q, m_g, 1'b0));
            check("m_trunc_busy", int'(bus_t.ramp_busy), int'(m_g != 0 && m_g != LEN));
        end
    end

    // Called at a falling edge: one strobe, then `gap` idle cycles with junk inputs.
    task automatic pulse(input bit v, input int i, input int q, input int gap);
        strobe = 1'b1;
        valid  = v;
        in_i   = IN_W'(i);
        in_q   = IN_W'(q);
        @(negedge clock);
        strobe = 1'b0;
        valid  = 1'($urandom);
        in_i   = IN_W'($urandom);
        in_q   = IN_W'($urandom);
        repeat (gap) @(negedge clock);
    endtask

    int up0[4] = '{36, 40, 44, 48};
    int up1[4] = '{28, 24, 20, 16};
    int dn0[4] = '{44, 40, 36, 32};
    int dn1[4] = '{20, 24, 28, 32};
    bit prev_v;
    int ri;
    int rq;

    initial begin
        vectors = 0;
        errors  = 0;
        cmp_en  = 1'b0;
        strobe  = 1'b0;
        valid   = 1'b0;
        in_i    = '0;
        in_q    = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_zero", int'(bus0.dac_zero), 32);
        check("rst_one", int'(bus0.dac_one), 32);
        check("rst_tx", int'(bus0.txchain_en), 0);
        check("rst_busy", int'(bus0.ramp_busy), 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 4; k++) begin
            pulse(1'b1, 128, -128, 1);
            check("up_zero", int'(bus0.dac_zero), up0[k]);
            check("up_one", int'(bus0.dac_one), up1[k]);
            check("up_tx", int'(bus0.txchain_en), 1);
            check("up_busy", int'(bus0.ramp_busy), (k == 3) ? 0 : 1);
            check("swap_up_zero", int'(bus_s.dac_zero), up1[k]);
            check("swap_up_one", int'(bus_s.dac_one), up0[k]);
        end

        pulse(1'b1, 255, -256, 1);
        check("sat_zero", int'(bus0.dac_zero), 63);
        check("sat_one", int'(bus0.dac_one), 0);
        check("trunc_sat_zero", int'(bus_t.dac_zero), 63);
        check("swap_sat_zero", int'(bus_s.dac_zero), 0);

        pulse(1'b1, 128, -128, 1);
        check("act_zero", int'(bus0.dac_zero), 48);
        for (int k = 0; k < 4; k++) begin
            pulse(1'b0, 0, 0, 1);
            check("dn_zero", int'(bus0.dac_zero), dn0[k]);
            check("dn_one", int'(bus0.dac_one), dn1[k]);
            check("dn_tx", int'(bus0.txchain_en), (k == 3) ? 0 : 1);
            check("dn_busy", int'(bus0.ramp_busy), (k == 3) ? 0 : 1);
        end

        for (int k = 0; k < 4; k++) pulse(1'b1, 128, -128, 0);
        pulse(1'b0, 0, 0, 0);
        pulse(1'b0, 0, 0, 1);
        check("rd_g2_zero", int'(bus0.dac_zero), 40);
        pulse(1'b1, 128, -128, 1);
        check("reup_zero", int'(bus0.dac_zero), 44);
        check("reup_tx", int'(bus0.txchain_en), 1);
        check("reup_busy", int'(bus0.ramp_busy), 1);
        pulse(1'b1, 128, -128, 1);
        check("reup_act_busy", int'(bus0.ramp_busy), 0);

        #2 reset_n = 1'b0;
        #1;
        check("arst_zero", int'(bus0.dac_zero), 32);
        check("arst_one", int'(bus0.dac_one), 32);
        check("arst_tx", int'(bus0.txchain_en), 0);
        #1 reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("post_rst_hold", int'(bus0.dac_zero), 32);
        pulse(1'b1, 128, -128, 1);
        check("restart_zero", int'(bus0.dac_zero), 36);
        check("restart_busy", int'(bus0.ramp_busy), 1);

        prev_v = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 reset_n = 1'b0;
                #3 reset_n = 1'b1;
                @(negedge clock);
            end else begin
                if ($urandom_range(0, 3) == 0) prev_v = ~prev_v;
                case ($urandom_range(0, 5))
                    0: ri = 255;
                    1: ri = -256;
                    default: ri = $urandom_range(0, 511) - 256;
                endcase
                case ($urandom_range(0, 5))
                    0: rq = -256;
                    1: rq = 255;
                    default: rq = $urandom_range(0, 511) - 256;
                endcase
                pulse(prev_v, ri, rq, $urandom_range(0, 2));
            end
        end

        @(negedge clock);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/iq_dac_driver.md
IQ_DAC_DRIVER -- requirements
Module: iq_dac_driver

Interface
REQ-001 Parameter IN_W, default 9: signed width of the modulator I/Q input samples.
REQ-002 Parameter DAC_W, default 6: width of each offset-binary DAC output; IN_W > DAC_W SHALL hold.
REQ-003 Parameter RAMP_LOG2, default 2: ramp length RAMP_LEN = 2^RAMP_LOG2 sample strobes.
REQ-004 Parameter ROUND, default 1: 1 = round-half-up on requantisation, 0 = truncate.
REQ-005 Parameter SWAP_IQ, default 0: 1 routes I to dac_one and Q to dac_zero.
REQ-006 clock  input  1  sole clock, all state on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 sample_strobe  input  1  one-cycle pulse marking a new input sample.
REQ-009 iq_valid  input  1  burst-active qualifier, sampled only on sample_strobe.
REQ-010 inphase_in  input  IN_W  signed two's-complement I sample.
REQ-011 quadrature_in  input  IN_W  signed two's-complement Q sample.
REQ-012 dac_zero  output  DAC_W  registered offset-binary I code (Q if SWAP_IQ).
REQ-013 dac_one  output  DAC_W  registered offset-binary Q code (I if SWAP_IQ).
REQ-014 txchain_en  output  1  RF chain enable, high in every state except IDLE.
REQ-015 ramp_busy  output  1  high in RAMP_UP and RAMP_DOWN.

Function
REQ-016 State and outputs SHALL change only on clock edges where sample_strobe=1; outputs otherwise hold.
REQ-017 States: IDLE, RAMP_UP, ACTIVE, RAMP_DOWN; gain register g is in 0..RAMP_LEN.
REQ-018 IDLE: iq_valid=1 -> RAMP_UP, g=1; iq_valid=0 -> stay, g=0.
REQ-019 RAMP_UP: iq_valid=1 -> g+1, enter ACTIVE when g reaches RAMP_LEN; iq_valid=0 -> RAMP_DOWN, g-1 (IDLE if g reaches 0).
REQ-020 ACTIVE: iq_valid=1 -> stay, g=RAMP_LEN; iq_valid=0 -> RAMP_DOWN, g=RAMP_LEN-1.
REQ-021 RAMP_DOWN: iq_valid=0 -> g-1, enter IDLE when g reaches 0; iq_valid=1 -> RAMP_UP, g+1.
REQ-022 A held sample register SHALL capture the inputs on every strobe with iq_valid=1; strobes with iq_valid=0 use the held sample.
REQ-023 Datapath per channel, using the new g: p = x*g (IN_W+RAMP_LOG2+1 bits signed); s = p >>> RAMP_LOG2 (arithmetic).
REQ-024 Requantise: r = (s + (ROUND ? 2^(IN_W-DAC_W-1) : 0)) >>> (IN_W-DAC_W), computed without overflow.
REQ-025 Saturate r to [-2^(DAC_W-1), 2^(DAC_W-1)-1]; output code = r + 2^(DAC_W-1) (MSB inversion).
REQ-026 When the new state is IDLE, both outputs SHALL be midscale 2^(DAC_W-1) regardless of inputs.
REQ-027 Latency: outputs, txchain_en and ramp_busy update on the same edge that samples sample_strobe (one registered stage).
REQ-028 txchain_en SHALL rise on the strobe leaving IDLE and fall on the strobe entering IDLE.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, g=0, held samples 0, dac_zero=dac_one=2^(DAC_W-1), txchain_en=0, ramp_busy=0.
REQ-030 Reset asserted mid-burst SHALL abort without ramp-down; after release, operation restarts from IDLE on the next strobe.

Verification (IN_W=9, DAC_W=6, RAMP_LOG2=2, ROUND=1, SWAP_IQ=0)
REQ-031 Reset -> dac_zero=32, dac_one=32, txchain_en=0, ramp_busy=0.
REQ-032 iq_valid=1, I=+128, Q=-128, strobes 1..4 -> dac_zero 36,40,44,48; dac_one 28,24,20,16; ACTIVE after strobe 4; ramp_busy low from strobe 4.
REQ-033 From ACTIVE, iq_valid=0 on 4 strobes -> dac_zero 44,40,36,32; txchain_en falls on the 4th strobe.
REQ-034 ACTIVE, I=+255, Q=-256 -> dac_zero=63, dac_one=0 (saturation both rails); ROUND=0, I=+255 -> 63.
REQ-035 RAMP_DOWN at g=2, iq_valid reasserted -> RAMP_UP, g=3, dac_zero=44 for I=+128, txchain_en stays high.
REQ-036 reset_n pulsed low between strobes while ACTIVE -> outputs 32/32 asynchronously; no change until next strobe; SWAP_IQ=1 run swaps dac_zero/dac_one codes of REQ-032.
